instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
Fetch stage that sits directly upstream of the decoder in the MIPS-subset core. Owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PC in a small FIFO. Presents them to decode with a valid/ready handshake. Redirects (jump, jr, taken bne) from execute flush the queue and restart fetch.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned fetch address; stable while imem_req is high
imem_ack  input  1  one-cycle pulse: imem_data is valid for the current request (may arrive in the same cycle as imem_req)
imem_data  input  32  returned instruction word
redirect  input  1  one-cycle pulse: discard all fetched and in-flight words, restart at redirect_pc
redirect_pc  input  32  new fetch target; bits [1:0] ignored and forced to 0
instr_valid  output  1  head entry valid
instr_ready  input  1  decode accepts head this cycle
instr_out  output  32  head instruction word
instr_pc  output  32  PC of head instruction
instr_pc_inc  output  32  instr_pc + 4, used for jal link and bne base

Behaviour:
- Reset (async, rst high):
  - state=FETCH, fpc=RESET_PC, pend_pc=0, count=0, rd/wr pointers=0.
  - Outputs during reset: imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, instr_pc_inc=4.
  - The first request is asserted in the first cycle after rst falls.
- All outputs are driven from registers only. There is no combinational path from imem_ack, redirect or instr_ready to any output.
- States:
  - FETCH: imem_req = (count < DEPTH), imem_addr = fpc.
  - DISCARD: imem_req=1, imem_addr=fpc (the killed address); the response is dropped.
- At most one request is outstanding. While imem_req is high, imem_addr does not change until imem_ack.
- FETCH, on imem_ack with no redirect: push {imem_data, fpc}; fpc <= fpc+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- FETCH, on redirect:
  - Flush the queue (count=0, pointers reset).
  - If a request is outstanding without ack this cycle: pend_pc <= redirect_pc, go to DISCARD.
  - Otherwise, including when the ack lands in the same cycle as redirect (data dropped): fpc <= redirect_pc, stay in FETCH.
- DISCARD:
  - On imem_ack: fpc <= pend_pc, go to FETCH, push nothing.
  - A further redirect overwrites pend_pc; the last redirect wins.
  - Redirect and ack in the same cycle: fpc <= the new redirect_pc, go to FETCH.
- Queue:
  - instr_valid = (count != 0); head fields come from the rd pointer.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - The full queue never receives a push, because a request is only issued when count < DEPTH and count cannot grow while waiting.
  - Pop on an empty queue is ignored.
- Redirect has priority over pop. The flush takes effect next cycle (instr_valid=0). A pop in the redirect cycle is still a legal handoff of the current head.
- Throughput: with a zero-latency memory (ack in the request cycle) and decode always ready, one instruction per cycle.
- Redirect-to-first-valid latency: 1 cycle plus memory latency, plus the drain time of any killed request.

Decomposition:
- Shared package/header: FSM state encodings (ST_FETCH, ST_DISCARD), and the WORD_BYTES=4 and PC_ALIGN_MASK constants.
- Sub-module: fetch_fifo, a parameterised synchronous FIFO of {pc, instr}, DEPTH deep. It has a flush input and exposes count/full/empty.
- The FSM, fpc and pend_pc live in the top level.

Test Plan:
- Reset, then zero-latency memory (ack same cycle), instr_ready=1 -> imem_addr 0,4,8,… on consecutive cycles; instr_pc 0,4,8 with instr_out matching mem words, one per cycle.
- instr_ready=0, DEPTH=4 -> exactly 4 acks (addresses 0..12), then imem_req=0. Raise ready for one cycle -> one pop, and next cycle imem_req=1 at addr 16.
- 3-cycle ack latency, redirect to 0x40 in the cycle after a req to 0x8 -> req stays at 0x8 until ack, data dropped, next req at 0x40, first instr_valid carries instr_pc=0x40.
- In DISCARD, redirect to 0x40 then redirect to 0x80 before ack -> only 0x80 fetched. Redirect coincident with ack and with pop -> ack data dropped, queue empty next cycle.
- redirect_pc=0x103 -> fetch at 0x100. fpc reaching 0xFFFF_FFFC -> next fetch address 0x0, and instr_pc_inc shows 0x0.
- Assert rst mid-DISCARD with 2 queued entries -> outputs immediately at reset values. After release, first req at RESET_PC, and no stale ack is pushed.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES    = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory and decode-side handshakes of the fetch stage.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_inc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output instr_valid, instr_out, instr_pc, instr_pc_inc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  instr_valid, instr_out, instr_pc, instr_pc_inc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of {pc, instr} with flush; flush beats push and pop.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues imem reads, queues words for decode.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  instr_fetch_queue_if.master        bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [31:0]       fpc;
  logic [31:0]       fpc_next;
  logic [31:0]       pend_pc;
  logic [31:0]       pend_next;
  logic [31:0]       target;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              req;
  logic              ack;
  logic              push;
  logic              pop;
  logic              flush;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;

  assign target   = align_pc(redirect_pc);
  assign ack      = req && bus.imem_ack;
  assign pop      = !empty && bus.instr_ready;
  assign wr_entry = '{pc: fpc, instr: bus.imem_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc     <= RESET_PC;
      pend_pc <= '0;
    end else begin
      fpc     <= fpc_next;
      pend_pc <= pend_next;
    end
  end

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    pend_next  = pend_pc;
    push       = 1'b0;
    flush      = redirect;
    unique case (state)
      ST_FETCH: begin
        if (redirect) begin
          // A live request cannot be withdrawn, so its response is drained.
          if (req && !bus.imem_ack) begin
            pend_next  = target;
            state_next = ST_DISCARD;
          end else begin
            fpc_next = target;
          end
        end else if (ack) begin
          push     = !full;
          fpc_next = fpc + WORD_BYTES;
        end
      end
      ST_DISCARD: begin
        if (ack) begin
          fpc_next   = redirect ? target : pend_pc;
          state_next = ST_FETCH;
        end else if (redirect) begin
          pend_next = target;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    req = 1'b0;
    unique case (state)
      ST_FETCH:   req = (count < CNT_W'(DEPTH));
      ST_DISCARD: req = 1'b1;
      default:    req = 1'b0;
    endcase
    if (rst) req = 1'b0;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.imem_req     = req;
  assign bus.imem_addr    = fpc;
  assign bus.instr_valid  = !empty;
  assign bus.instr_out    = head.instr;
  assign bus.instr_pc     = head.pc;
  assign bus.instr_pc_inc = head.pc + WORD_BYTES;

endmodule
